peripheral_mult_ctrl: RTL and testbench
=======================================

// Module: peripheral_mult_ctrl
// PURPOSE
//  Bus-slave controller for the multiplier peripheral. Buffers two 32-bit operands (written
//  bytewise by the CPU), sequences one multiply on an external 32x32 unit via init/done
//  handshake, latches the 64-bit product, exposes busy/done/err status. Sits between the
//  8-bit peripheral bus and the multiplier datapath.
// PARAMETERS
//  OP_W     32   operand width (A, B); product is 2*OP_W
//  TIMEOUT  255  max cycles in WAIT before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk        in   1     single clock, rising edge
//  reset      in   1     asynchronous, active-high; all state cleared immediately
//  cs         in   1     chip select
//  wr         in   1     1=write, 0=read (qualified by cs)
//  addr       in   4     register address
//  d_in       in   8     write data
//  d_out      out  8     read data, registered
//  mult_init  out  1     one-cycle start pulse to multiplier
//  mult_a     out  OP_W  operand A (stable IDLE->DONE)
//  mult_b     out  OP_W  operand B
//  mult_done  in   1     multiplier completion, product valid same cycle
//  mult_pp    in   2*OP_W product
//  irq        out  1     only with PERIPHERAL_MULT_IRQ_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: d_out=0, mult_init=0, mult_a/b=0, result=0, busy=done=err=0, state IDLE, irq=0.
//  Map: wr 0x0-0x7 -> operand byte addr[2:0] (A=bytes 0-3, B=4-7, little-endian);
//   rd 0x0-0x7 -> result byte addr[2:0]; wr 0x8: bit0 start, bit1 clear done/err;
//   rd 0x9 -> {5'b0, err, done, busy}; other rd -> 0x00; other wr ignored.
//  Read latency 1 cycle: d_out updates on the edge after cs&!wr; holds otherwise.
//  FSM: IDLE -(start)-> START: mult_init=1 one cycle -> WAIT: count cycles;
//   mult_done -> latch mult_pp into result, DONE; count==TIMEOUT -> err=1, IDLE.
//   DONE -> IDLE next cycle with done=1 (sticky until bit1 clear or new start).
//  busy=1 in START/WAIT/DONE. start in IDLE clears done/err same edge.
//  Writes to 0x0-0x7 or start while busy: ignored, err=1; in-flight op unaffected.
//  Start and clear in same write: clear applies, then start accepted.
//  mult_done outside WAIT ignored. Counter resets on entering START.
//  Reset mid-operation: abort, result and operands cleared, no partial latch.
// CONFIGURATION
//  PERIPHERAL_MULT_IRQ_EN defined: irq is a level output = done|err, drops on clear
//   (wr 0x8 bit1) or on the next start. Undefined: irq port absent; software polls 0x9.
// STRUCTURE
//  Package peripheral_mult_pkg: state enum (IDLE,START,WAIT,DONE), address localparams
//   (ADDR_CTRL=4'h8, ADDR_STAT=4'h9), status/ctrl bit-position localparams.
//  Sub-module peripheral_operand_buffer: clocked 8-byte register, byte write-enable,
//   write-inhibit input (busy), outputs A/B. FSM, counter, result reg, bus decode at top.
// TESTING
//  Write 0x0..0x7 = 03,00,00,00,05,00,00,00, start; model done after 4 cycles with
//   pp=15 -> init pulse 1 cycle, busy during, rd 0x9=0x02, rd 0x0=0x0F, rd 0x1..0x7=0.
//  A=0xFFFFFFFF, B=0xFFFFFFFF, pp=0xFFFFFFFE00000001 -> result bytes 01,00,00,00,FE,FF,FF,FF.
//  Model never asserts done -> after TIMEOUT=255 cycles in WAIT: rd 0x9=0x04, busy=0.
//  During WAIT write 0x0=AA, then done -> err=1, mult_a unchanged, result correct.
//  Assert reset in WAIT -> all outputs 0 immediately; later done ignored, rd 0x9=0x00.
//  IRQ_EN build: done -> irq=1; wr 0x8=0x02 -> irq=0 and rd 0x9=0x00 next cycle.

Source files
------------

// File: rtl/peripheral_mult_pkg.sv
// peripheral_mult_pkg: state encodings, register map and status/ctrl bit positions for the multiplier peripheral
package peripheral_mult_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [3:0] ADDR_CTRL = 4'h8;
  localparam logic [3:0] ADDR_STAT = 4'h9;
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERR   = 2;
  // Packs the status flags into the byte returned at ADDR_STAT
  function automatic logic [7:0] stat_byte(input logic busy, input logic done, input logic err);
    logic [7:0] s;
    s            = '0;
    s[STAT_BUSY] = busy;
    s[STAT_DONE] = done;
    s[STAT_ERR]  = err;
    return s;
  endfunction
endpackage

// File: rtl/peripheral_mult_if.sv
// peripheral_mult_if: 8-bit peripheral bus plus multiplier init/done handshake
interface peripheral_mult_if #(
  parameter int OP_W = 32
);
  logic              cs;
  logic              wr;
  logic [3:0]        addr;
  logic [7:0]        d_in;
  logic [7:0]        d_out;
  logic              mult_init;
  logic [OP_W-1:0]   mult_a;
  logic [OP_W-1:0]   mult_b;
  logic              mult_done;
  logic [2*OP_W-1:0] mult_pp;
  modport slave (
    input  cs, wr, addr, d_in, mult_done, mult_pp,
    output d_out, mult_init, mult_a, mult_b
  );
  modport master (
    output cs, wr, addr, d_in, mult_done, mult_pp,
    input  d_out, mult_init, mult_a, mult_b
  );
endinterface

// File: rtl/peripheral_operand_buffer.sv
// peripheral_operand_buffer: 8-byte operand store (A = bytes 0-3, B = bytes 4-7, little-endian) frozen while inhibited
module peripheral_operand_buffer #(
  parameter int OP_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            inhibit,
  input  logic [2:0]      idx,
  input  logic [7:0]      d,
  output logic [OP_W-1:0] a,
  output logic [OP_W-1:0] b
);
  logic [2*OP_W-1:0] ops_q, ops_d;
  // Byte write unless an operation is in flight
  always_comb begin
    ops_d = ops_q;
    if (we && !inhibit) ops_d[{idx, 3'b000} +: 8] = d;
  end
  // Operand storage
  always_ff @(posedge clk or posedge reset)
    if (reset) ops_q <= '0;
    else ops_q <= ops_d;
  assign a = ops_q[OP_W-1:0];
  assign b = ops_q[2*OP_W-1:OP_W];
endmodule

// File: rtl/peripheral_mult_ctrl.sv
// peripheral_mult_ctrl: bus-slave controller sequencing one multiply; define PERIPHERAL_MULT_IRQ_EN for a done|err irq output
module peripheral_mult_ctrl
  import peripheral_mult_pkg::*;
#(
  parameter int OP_W    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
`ifdef PERIPHERAL_MULT_IRQ_EN
  output logic irq,
`endif
  peripheral_mult_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*OP_W-1:0] res_q, res_d;
  logic              done_q, done_d, err_q, err_d;
  logic [7:0]        dout_q, dout_d;
  logic [OP_W-1:0]   op_a, op_b;
  logic              busy, rd_en, op_wr, ctrl_wr, start_req, clr_req;
  assign busy      = state_q != S_IDLE;
  assign rd_en     = bus.cs & ~bus.wr;
  assign op_wr     = bus.cs & bus.wr & ~bus.addr[3];
  assign ctrl_wr   = bus.cs & bus.wr & (bus.addr == ADDR_CTRL);
  assign start_req = ctrl_wr & bus.d_in[CTRL_START];
  assign clr_req   = ctrl_wr & bus.d_in[CTRL_CLEAR];
  peripheral_operand_buffer #(.OP_W(OP_W)) u_ops (
    .clk     (clk),
    .reset   (reset),
    .we      (op_wr),
    .inhibit (busy),
    .idx     (bus.addr[2:0]),
    .d       (bus.d_in),
    .a       (op_a),
    .b       (op_b)
  );
  assign bus.mult_a    = op_a;
  assign bus.mult_b    = op_b;
  assign bus.mult_init = state_q == S_START;
  assign bus.d_out     = dout_q;
`ifdef PERIPHERAL_MULT_IRQ_EN
  assign irq = done_q | err_q;
`endif
  // Sequencer: clear first, then error events and FSM transitions override
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = done_q;
    err_d   = err_q;
    if (clr_req) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (busy && (op_wr || start_req)) err_d = 1'b1;
    case (state_q)
      S_IDLE: if (start_req) begin
        state_d = S_START;
        cnt_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: if (bus.mult_done) begin
        res_d   = bus.mult_pp;
        state_d = S_DONE;
      end else if (cnt_q == CW'(TIMEOUT)) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else cnt_d = cnt_q + 1'b1;
      default: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end
  // Registered read data: result bytes, status, or zero for unmapped addresses
  always_comb
    dout_d = !rd_en ? dout_q :
             !bus.addr[3] ? res_q[{bus.addr[2:0], 3'b000} +: 8] :
             bus.addr == ADDR_STAT ? stat_byte(busy, done_q, err_q) : 8'h00;
  // Controller state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
endmodule

// File: tb/tb_peripheral_mult_ctrl.sv
// tb_peripheral_mult_ctrl: scoreboard bench with a behavioural register/multiplier model
module tb_peripheral_mult_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef PERIPHERAL_MULT_IRQ_EN
  logic irq;
`endif
  peripheral_mult_if #(.OP_W(32)) b ();
  peripheral_mult_ctrl #(.OP_W(32), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef PERIPHERAL_MULT_IRQ_EN
    .irq   (irq),
`endif
    .bus   (b)
  );
  always #5 clk = ~clk;

  typedef struct { logic [3:0] a; logic [7:0] v; } rd_exp_t;
  rd_exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [7:0]  m_ops[8];
  logic [63:0] m_res, m_prod;
  bit m_busy, m_done, m_err;
  int lat_cfg = 4;
  bit no_done = 1'b0;
  int stray_req = 0, stray_ack = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_a();
    return {m_ops[3], m_ops[2], m_ops[1], m_ops[0]};
  endfunction
  function automatic logic [31:0] m_b();
    return {m_ops[7], m_ops[6], m_ops[5], m_ops[4]};
  endfunction
  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (a < 4'h8) return m_res[a*8 +: 8];
    if (a == 4'h9) return {5'b0, m_err, m_done, m_busy};
    return 8'h00;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_ops[i] = 8'h00;
    m_res = '0;
    m_busy = 0; m_done = 0; m_err = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    if (a < 4'h8) begin
      if (m_busy) m_err = 1;
      else m_ops[a[2:0]] = d;
    end else if (a == 4'h8) begin
      if (d[1]) begin m_done = 0; m_err = 0; end
      if (d[0]) begin
        if (m_busy) m_err = 1;
        else begin
          m_busy = 1; m_done = 0; m_err = 0;
          m_prod = {32'b0, m_a()} * {32'b0, m_b()};
        end
      end
    end
    b.cs = 1; b.wr = 1; b.addr = a; b.d_in = d;
    @(negedge clk);
    b.cs = 0; b.wr = 0;
  endtask

  task automatic rd(input logic [3:0] a);
    sb.push_back('{a, m_read(a)});
    b.cs = 1; b.wr = 0; b.addr = a;
    @(negedge clk);
    b.cs = 0;
  endtask

  task automatic load_ops(input logic [31:0] a, input logic [31:0] bb);
    logic [63:0] v;
    v = {bb, a};
    for (int i = 0; i < 8; i++) wr(4'(i), v[i*8 +: 8]);
  endtask

  task automatic run_op(input int lat, input logic [7:0] ctrl, input bit bwr, input logic [3:0] ba, input logic [7:0] bd);
    lat_cfg = lat;
    wr(4'h8, ctrl);
    rd(4'h9);
    if (bwr) wr(ba, bd);
    rd(4'h9);
    repeat (lat + 6) @(negedge clk);
    m_busy = 0; m_done = 1; m_res = m_prod;
    for (int i = 0; i < 8; i++) rd(4'(i));
    rd(4'h9);
    chk("mult_a_hold", b.mult_a, m_a());
    chk("mult_b_hold", b.mult_b, m_b());
`ifdef PERIPHERAL_MULT_IRQ_EN
    chk("irq_done", irq, m_done | m_err);
`endif
  endtask

  // Read monitor: a read sampled on one edge is checked on the following falling edge
  initial forever begin
    @(posedge clk);
    if (b.cs && !b.wr && !reset) begin
      @(negedge clk);
      if (sb.size() == 0) chk("rd_unexpected", b.d_out, 8'hxx);
      else begin
        rd_exp_t e;
        e = sb.pop_front();
        chk($sformatf("rd_0x%h", e.a), b.d_out, e.v);
      end
    end
  end

  // Multiplier model: answers each init pulse after lat_cfg cycles with the product of its pins
  initial begin
    b.mult_done = 0;
    b.mult_pp = '0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        b.mult_done = 1;
        b.mult_pp = {$urandom, $urandom};
        @(negedge clk);
        b.mult_done = 0;
      end else if (b.mult_init && !no_done) begin
        chk("mult_a_init", b.mult_a, m_a());
        chk("mult_b_init", b.mult_b, m_b());
        repeat (lat_cfg) @(negedge clk);
        b.mult_done = 1;
        b.mult_pp = {32'b0, b.mult_a} * {32'b0, b.mult_b};
        @(negedge clk);
        b.mult_done = 0;
        b.mult_pp = {$urandom, $urandom};
      end
    end
  end

  // Init pulse must be exactly one cycle wide
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (b.mult_init) run++;
      else if (run != 0) begin
        chk("init_width", run, 1);
        run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    b.cs = 0; b.wr = 0; b.addr = 0; b.d_in = 0;
    m_reset();
    m_prod = '0;
    repeat (3) @(negedge clk);
    chk("rst_d_out", b.d_out, 8'h00);
    chk("rst_init", b.mult_init, 1'b0);
    chk("rst_a", b.mult_a, 32'h0);
    chk("rst_b", b.mult_b, 32'h0);
    reset = 0;
    @(negedge clk);
    rd(4'h9);
    rd(4'h0);
    // 3 * 5
    load_ops(32'd3, 32'd5);
    run_op(4, 8'h01, 0, 4'h0, 8'h00);
    // all ones
    load_ops(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(7, 8'h01, 0, 4'h0, 8'h00);
    // operand write during WAIT is rejected and flags err
    load_ops(32'h1234_5678, 32'h0000_0010);
    run_op(6, 8'h01, 1, 4'h0, 8'hAA);
    wr(4'h8, 8'h02);
    rd(4'h9);
`ifdef PERIPHERAL_MULT_IRQ_EN
    chk("irq_clear", irq, 1'b0);
`endif
    wr(4'hC, 8'hFF);
    rd(4'h9);
    rd(4'hC);
    rd(4'h8);
    rd(4'h2);
    // stray done while idle is ignored
    stray_req++;
    repeat (3) @(negedge clk);
    rd(4'h0);
    rd(4'h7);
    // timeout
    no_done = 1;
    load_ops(32'h0000_0007, 32'h0000_0009);
    wr(4'h8, 8'h01);
    repeat (200) @(negedge clk);
    rd(4'h9);
    repeat (100) @(negedge clk);
    m_busy = 0; m_err = 1;
    rd(4'h9);
`ifdef PERIPHERAL_MULT_IRQ_EN
    chk("irq_err", irq, 1'b1);
`endif
    no_done = 0;
    // randomized operations
    for (int n = 0; n < 16; n++) begin
      int p;
      p = $urandom_range(0, 3);
      ra = p == 0 ? 32'h0 : p == 1 ? 32'hFFFF_FFFF : $urandom;
      p = $urandom_range(0, 3);
      rb = p == 0 ? 32'h0 : p == 1 ? 32'hFFFF_FFFF : $urandom;
      load_ops(ra, rb);
      run_op($urandom_range(4, 20), $urandom_range(0, 1) ? 8'h03 : 8'h01,
             $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)), 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        wr(4'h8, 8'h02);
        rd(4'h9);
      end
      if ($urandom_range(0, 2) == 0) begin
        stray_req++;
        repeat (3) @(negedge clk);
        rd(4'($urandom_range(0, 7)));
      end
      rd(4'($urandom_range(10, 15)));
    end
    // reset in the middle of WAIT
    no_done = 1;
    load_ops(32'hDEAD_BEEF, 32'h0BAD_F00D);
    wr(4'h8, 8'h01);
    rd(4'h9);
    repeat (5) @(negedge clk);
    #1 reset = 1;
    #1;
    chk("arst_d_out", b.d_out, 8'h00);
    chk("arst_init", b.mult_init, 1'b0);
    chk("arst_a", b.mult_a, 32'h0);
    chk("arst_b", b.mult_b, 32'h0);
`ifdef PERIPHERAL_MULT_IRQ_EN
    chk("arst_irq", irq, 1'b0);
`endif
    m_reset();
    @(negedge clk);
    reset = 0;
    stray_req++;
    repeat (3) @(negedge clk);
    rd(4'h9);
    rd(4'h0);
    rd(4'h7);
    chk("post_rst_a", b.mult_a, 32'h0);
    no_done = 0;
    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
